// File: rtl/crossbar_pkg.sv
// crossbar_pkg: shared command encodings, address fields, widths and slave FSM states
package crossbar_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int SEL_MSB = 31;
    localparam int SEL_LSB = 30;
    localparam logic CMD_READ = 1'b0;
    localparam logic CMD_WRITE = 1'b1;
    typedef enum logic [2:0] {S_IDLE, S_DELAY, S_ACK, S_WAIT, S_RESP} slv_state_t;
endpackage

// File: rtl/crossbar_slave_ram.sv
// crossbar_slave_ram: single-port word RAM with write enable and one-cycle registered read
module crossbar_slave_ram
    import crossbar_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    localparam int IDX_W = $clog2(MEM_DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [MEM_DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
        if (re) rdata <= mem[idx];
    end
endmodule

// File: rtl/crossbar_slave_mem.sv
// crossbar_slave_mem: memory-backed crossbar slave terminating req/ack/cmd/resp, one transaction at a time
module crossbar_slave_mem
    import crossbar_pkg::*;
#(
    parameter int MEM_DEPTH = 256,
    parameter int ACK_DELAY = 0,
    parameter int READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              slave_req,
    output logic              slave_ack,
    input  logic              slave_cmd,
    input  logic [ADDR_W-1:0] slave_addr,
    input  logic [DATA_W-1:0] slave_wdata,
    output logic              slave_resp,
    output logic [DATA_W-1:0] slave_rdata,
    output logic              busy,
    output logic [15:0]       wr_count,
    output logic [15:0]       rd_count,
    output logic [7:0]        oor_count
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    slv_state_t state, next;
    logic [3:0] cnt, cnt_next;
    logic cmd_q, oor_q, we, re;
    logic [IDX_W-1:0] idx_q;
    logic [DATA_W-1:0] wdata_q, ram_rdata;
    logic unused_addr;
    assign unused_addr = ^{slave_addr[SEL_MSB:SEL_LSB], slave_addr[1:0]};
    assign we = state == S_ACK && cmd_q == CMD_WRITE && !oor_q;
    assign re = state == S_ACK && cmd_q == CMD_READ;
    // Only register outputs feed this gate, so no input-to-output path exists.
    assign slave_rdata = (slave_resp && !oor_q) ? ram_rdata : '0;
    always_comb begin
        next = state;
        cnt_next = cnt;
        case (state)
            S_IDLE: if (slave_req) begin
                next = ACK_DELAY > 0 ? S_DELAY : S_ACK;
                cnt_next = 4'(ACK_DELAY - 1);
            end
            S_DELAY: begin
                if (!slave_req) next = S_IDLE;
                else if (cnt == '0) next = S_ACK;
                else cnt_next = cnt - 4'd1;
            end
            S_ACK: begin
                next = cmd_q == CMD_WRITE ? S_IDLE : (READ_LATENCY > 1 ? S_WAIT : S_RESP);
                cnt_next = 4'(READ_LATENCY - 2);
            end
            S_WAIT: begin
                if (cnt == '0) next = S_RESP;
                else cnt_next = cnt - 4'd1;
            end
            default: next = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt <= '0;
            slave_ack <= 1'b0;
            slave_resp <= 1'b0;
            busy <= 1'b0;
            wr_count <= '0;
            rd_count <= '0;
            oor_count <= '0;
        end else begin
            state <= next;
            cnt <= cnt_next;
            slave_ack <= next == S_ACK;
            slave_resp <= next == S_RESP;
            busy <= next != S_IDLE;
            if (state == S_ACK && cmd_q == CMD_WRITE && wr_count != '1) wr_count <= wr_count + 16'd1;
            if (state == S_RESP && rd_count != '1) rd_count <= rd_count + 16'd1;
            if (state == S_ACK && oor_q && oor_count != '1) oor_count <= oor_count + 8'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (state == S_IDLE && slave_req) begin
            cmd_q <= slave_cmd;
            idx_q <= slave_addr[IDX_W+1:2];
            oor_q <= |slave_addr[SEL_LSB-1:IDX_W+2];
            wdata_q <= slave_wdata;
        end
    end
    crossbar_slave_ram #(.MEM_DEPTH(MEM_DEPTH)) u_ram (
        .clk(clk),
        .we(we),
        .re(re),
        .idx(idx_q),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );
endmodule

// File: tb/tb_crossbar_slave_mem.sv
// tb_crossbar_slave_mem: directed self-checking bench for the memory-backed crossbar slave
module tb_crossbar_slave_mem;
    import crossbar_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic req = 1'b0, cmd = 1'b0, d_req = 1'b0, d_cmd = 1'b0;
    logic [31:0] addr = '0, wdata = '0, d_addr = '0, d_wdata = '0;
    logic ack, resp, busy, d_ack, d_resp, d_busy;
    logic [31:0] rdata, d_rdata;
    logic [15:0] wr_count, rd_count, d_wr_count, d_rd_count;
    logic [7:0] oor_count, d_oor_count;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    crossbar_slave_mem dut (
        .clk(clk), .reset(reset), .slave_req(req), .slave_ack(ack), .slave_cmd(cmd),
        .slave_addr(addr), .slave_wdata(wdata), .slave_resp(resp), .slave_rdata(rdata),
        .busy(busy), .wr_count(wr_count), .rd_count(rd_count), .oor_count(oor_count)
    );
    crossbar_slave_mem #(.MEM_DEPTH(256), .ACK_DELAY(3), .READ_LATENCY(1)) dut_d (
        .clk(clk), .reset(reset), .slave_req(d_req), .slave_ack(d_ack), .slave_cmd(d_cmd),
        .slave_addr(d_addr), .slave_wdata(d_wdata), .slave_resp(d_resp), .slave_rdata(d_rdata),
        .busy(d_busy), .wr_count(d_wr_count), .rd_count(d_rd_count), .oor_count(d_oor_count)
    );
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    // Drives one transaction; ac/rc are the cycles (cycle 0 = req sampled) of ack and resp, -1 if absent.
    task automatic xact(input bit sel, input logic c, input logic [31:0] a, input logic [31:0] wd,
                        output int ac, output int rc, output logic [31:0] rd);
        ac = -1;
        rc = -1;
        rd = '0;
        if (sel) begin d_req = 1'b1; d_cmd = c; d_addr = a; d_wdata = wd; end
        else begin req = 1'b1; cmd = c; addr = a; wdata = wd; end
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if ((sel ? d_ack : ack) && ac < 0) begin ac = n; req = 1'b0; d_req = 1'b0; end
            if (sel ? d_resp : resp) begin rc = n; rd = sel ? d_rdata : rdata; end
            if (ac > 0 && (c == CMD_WRITE || rc > 0)) break;
        end
        req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
    endtask
    initial begin
        int ac, rc, seen;
        logic [31:0] rd;
        repeat (2) @(negedge clk);
        check("rst_ack", ack, 0);
        check("rst_resp", resp, 0);
        check("rst_rdata", rdata, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_count", wr_count, 0);
        check("rst_rd_count", rd_count, 0);
        check("rst_oor_count", oor_count, 0);
        reset = 1'b0;
        @(negedge clk);
        xact(0, CMD_WRITE, 32'h0000_0010, 32'hCAFE_0001, ac, rc, rd);
        check("wr_ack_cycle", ac, 1);
        check("wr_count_1", wr_count, 1);
        check("idle_busy", busy, 0);
        xact(0, CMD_READ, 32'h0000_0010, 32'h0, ac, rc, rd);
        check("rd_ack_cycle", ac, 1);
        check("rd_resp_cycle", rc, 3);
        check("rd_data", rd, 32'hCAFE_0001);
        check("rd_count_1", rd_count, 1);
        check("rdata_idle_zero", rdata, 0);
        xact(0, CMD_WRITE, 32'hC000_0004, 32'h1234_5678, ac, rc, rd);
        xact(0, CMD_READ, 32'h4000_0004, 32'h0, ac, rc, rd);
        check("sel_ignored_data", rd, 32'h1234_5678);
        check("sel_ignored_oor", oor_count, 0);
        check("wr_count_2", wr_count, 2);
        xact(0, CMD_WRITE, 32'h0000_0000, 32'h5A5A_0F0F, ac, rc, rd);
        xact(0, CMD_WRITE, 32'h0000_0400, 32'hDEAD_BEEF, ac, rc, rd);
        check("oor_wr_ack", ac, 1);
        check("oor_count_1", oor_count, 1);
        xact(0, CMD_READ, 32'h0000_0000, 32'h0, ac, rc, rd);
        check("oor_wr_dropped", rd, 32'h5A5A_0F0F);
        xact(0, CMD_READ, 32'h0000_0400, 32'h0, ac, rc, rd);
        check("oor_rd_resp_cycle", rc, 3);
        check("oor_rd_data", rd, 0);
        check("oor_count_2", oor_count, 2);
        d_req = 1'b1;
        d_cmd = CMD_WRITE;
        d_addr = 32'h0000_0008;
        d_wdata = 32'h1111_1111;
        @(negedge clk);
        check("dly_busy_c1", d_busy, 1);
        check("dly_ack_c1", d_ack, 0);
        @(negedge clk);
        check("dly_ack_c2", d_ack, 0);
        d_req = 1'b0;
        @(negedge clk);
        check("abort_busy_c3", d_busy, 0);
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            seen += int'(d_ack);
        end
        check("abort_no_ack", seen, 0);
        check("abort_wr_count", d_wr_count, 0);
        check("abort_oor_count", d_oor_count, 0);
        xact(1, CMD_WRITE, 32'h0000_0008, 32'h2222_2222, ac, rc, rd);
        check("dly_wr_ack_cycle", ac, 4);
        check("dly_wr_count", d_wr_count, 1);
        xact(1, CMD_READ, 32'h0000_0008, 32'h0, ac, rc, rd);
        check("dly_rd_ack_cycle", ac, 4);
        check("lat1_resp_cycle", rc, 5);
        check("lat1_rd_data", rd, 32'h2222_2222);
        check("dly_rd_count", d_rd_count, 1);
        req = 1'b1;
        cmd = CMD_READ;
        addr = 32'h0000_0010;
        @(negedge clk);
        check("rstw_ack", ack, 1);
        req = 1'b0;
        @(negedge clk);
        check("rstw_busy_wait", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("rstw_busy_async", busy, 0);
        check("rstw_resp_async", resp, 0);
        check("rstw_rdata_async", rdata, 0);
        check("rstw_rd_count_async", rd_count, 0);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            seen += int'(resp);
        end
        check("rstw_no_resp", seen, 0);
        xact(0, CMD_READ, 32'h0000_0010, 32'h0, ac, rc, rd);
        check("ram_kept_resp_cycle", rc, 3);
        check("ram_kept_data", rd, 32'hCAFE_0001);
        for (int i = 1; i <= 300; i++) begin
            xact(0, CMD_READ, 32'h0000_0400, 32'h0, ac, rc, rd);
            if (i == 254) check("oor_count_254", oor_count, 8'hFE);
            if (i == 255) check("oor_count_255", oor_count, 8'hFF);
        end
        check("oor_count_sat", oor_count, 8'hFF);
        check("rd_count_301", rd_count, 301);
        force dut.wr_count = 16'hFFFC;
        #1 release dut.wr_count;
        repeat (3) xact(0, CMD_WRITE, 32'h0000_0020, 32'h0, ac, rc, rd);
        check("wr_count_reach_max", wr_count, 16'hFFFF);
        repeat (2) xact(0, CMD_WRITE, 32'h0000_0020, 32'h0, ac, rc, rd);
        check("wr_count_sat", wr_count, 16'hFFFF);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
